// File: rtl/john_decoder.sv
// john_decoder: decodes and tracks a 4-bit Johnson counter.
// Legal codes are mapped to a binary index 0..7. A three-state tracker
// (SEARCH -> CONFIRM -> LOCKED) accepts only forward steps (i -> i+1 mod 8).
// It flags out-of-sequence codes, illegal codes, stalls and the 7 -> 0 wrap,
// and keeps a saturating error count. All outputs are registered.
module john_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] code_in,
  input  logic       err_clr,
  output logic [2:0] count,
  output logic       valid,
  output logic       locked,
  output logic       seq_err,
  output logic       illegal,
  output logic       stall,
  output logic       wrap,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  // count_q is also the stored index that the tracker compares against.
  // It is only ever loaded from a legal sample, so the two never differ.
  logic [2:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       locked_q, locked_d;
  logic       seq_err_q, seq_err_d;
  logic       illegal_q, illegal_d;
  logic       stall_q, stall_d;
  logic       wrap_q, wrap_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic       code_legal;
  logic [2:0] code_idx;
  logic [2:0] succ_idx;

  // Map the sampled Johnson code to its index and flag codes outside the set.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    code_legal = 1'b1;
    code_idx   = 3'd0;
    case (code_in)
      4'b0000: code_idx = 3'd0;
      4'b1000: code_idx = 3'd1;
      4'b1100: code_idx = 3'd2;
      4'b1110: code_idx = 3'd3;
      4'b1111: code_idx = 3'd4;
      4'b0111: code_idx = 3'd5;
      4'b0011: code_idx = 3'd6;
      4'b0001: code_idx = 3'd7;
      default: code_legal = 1'b0;
    endcase
  end

  // The 3-bit add wraps 7 -> 0 on its own, which gives the mod-8 successor.
  assign succ_idx = count_q + 3'd1;

  // Compute the next tracker state, the index, the event pulses and the error count.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    valid_d   = valid_q;
    seq_err_d = 1'b0;
    illegal_d = 1'b0;
    stall_d   = 1'b0;
    wrap_d    = 1'b0;

    if (en) begin
      if (!code_legal) begin
        // An illegal code drops any lock. The index is kept.
        illegal_d = 1'b1;
        valid_d   = 1'b0;
        state_d   = SEARCH;
      end else begin
        valid_d = 1'b1;
        count_d = code_idx;
        case (state_q)
          SEARCH: begin
            state_d = CONFIRM;
          end
          CONFIRM: begin
            // A legal code that is not the successor restarts confirmation
            // from the new index. It is not counted as a sequence error.
            if (code_idx == succ_idx) begin
              state_d = LOCKED;
            end
          end
          LOCKED: begin
            if (code_idx == succ_idx) begin
              wrap_d = (count_q == 3'd7);
            end else if (code_idx == count_q) begin
              stall_d = 1'b1;
            end else begin
              seq_err_d = 1'b1;
              state_d   = CONFIRM;
            end
          end
          default: begin
            state_d = SEARCH;
          end
        endcase
      end
    end

    locked_d = (state_d == LOCKED);

    // Clear wins over a simultaneous error. The count sticks at 255.
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 8'd0;
    end else if ((seq_err_d || illegal_d) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Register all state and outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together from the values present before the edge.
    if (!rst) begin
      state_q   <= SEARCH;
      count_q   <= 3'd0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      seq_err_q <= 1'b0;
      illegal_q <= 1'b0;
      stall_q   <= 1'b0;
      wrap_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      seq_err_q <= seq_err_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
      wrap_q    <= wrap_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign count   = count_q;
  assign valid   = valid_q;
  assign locked  = locked_q;
  assign seq_err = seq_err_q;
  assign illegal = illegal_q;
  assign stall   = stall_q;
  assign wrap    = wrap_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_john_decoder.sv
// tb_john_decoder: directed scenarios plus randomized traffic.
// Every edge is checked against a behavioural model built from the
// decoder's rules (code table lookup, forward-step tracking, saturating count).
module tb_john_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] code_in = 4'b0000;
  logic       err_clr = 1'b0;
  logic [2:0] count;
  logic       valid, locked, seq_err, illegal, stall, wrap;
  logic [7:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  john_decoder dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .code_in (code_in),
    .err_clr (err_clr),
    .count   (count),
    .valid   (valid),
    .locked  (locked),
    .seq_err (seq_err),
    .illegal (illegal),
    .stall   (stall),
    .wrap    (wrap),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Legal Johnson sequence. The position in the table is the index.
  logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1111, 4'b0111, 4'b0011, 4'b0001};

  // Reference model state: phase 0 = searching, 1 = confirming, 2 = locked.
  int m_phase = 0;
  int m_idx   = 0;
  bit m_valid = 0;
  bit m_seq = 0, m_ill = 0, m_stall = 0, m_wrap = 0;
  int m_err   = 0;

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied for that edge.
  task automatic model_edge(input bit r, input bit e, input logic [3:0] c, input bit clr);
    int d;
    bit ev;
    m_seq = 0; m_ill = 0; m_stall = 0; m_wrap = 0;
    if (!r) begin
      m_phase = 0; m_idx = 0; m_valid = 0; m_err = 0;
      return;
    end
    ev = 0;
    if (e) begin
      d = lookup(c);
      if (d < 0) begin
        m_ill = 1; m_valid = 0; m_phase = 0; ev = 1;
      end else begin
        m_valid = 1;
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) begin
          if (d == (m_idx + 1) % 8) m_phase = 2;
        end else begin
          if (d == (m_idx + 1) % 8) m_wrap = (m_idx == 7);
          else if (d == m_idx) m_stall = 1;
          else begin m_seq = 1; m_phase = 1; ev = 1; end
        end
        m_idx = d;
      end
    end
    if (clr) m_err = 0;
    else if (ev && m_err < 255) m_err = m_err + 1;
  endtask

  // Apply one edge's worth of stimulus, then compare every output afterwards.
  task automatic step(input string tag, input bit r, input bit e, input logic [3:0] c, input bit clr);
    logic [16:0] obs, exp;
    @(negedge clk);
    rst = r; en = e; code_in = c; err_clr = clr;
    @(posedge clk);
    model_edge(r, e, c, clr);
    #1;
    obs = {count, valid, locked, seq_err, illegal, stall, wrap, err_cnt};
    exp = {m_idx[2:0], m_valid, (m_phase == 2), m_seq, m_ill, m_stall, m_wrap, m_err[7:0]};
    check(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  task automatic feed(input string tag, input int idx);
    step(tag, 1'b1, 1'b1, codes[idx % 8], 1'b0);
  endtask

  initial begin
    logic [3:0] c;
    int r;

    // Reset state.
    step("reset", 1'b0, 1'b1, 4'b1100, 1'b1);
    step("reset2", 1'b0, 1'b0, 4'b0000, 1'b0);

    // Acquire lock on 0,1,2,3.
    for (int i = 0; i < 4; i++) feed("acquire", i);
    check("locked_after_acq", {31'd0, locked}, 32'd1);

    // Full cycle through the 7 -> 0 wrap.
    for (int i = 4; i < 10; i++) feed("wrap_cycle", i);
    check("count_after_wrap", {29'd0, count}, 32'd1);

    // Sequence error, then relock.
    feed("to2", 2);
    feed("seqerr", 4);
    check("seq_err_pulse", {31'd0, seq_err}, 32'd1);
    feed("relock", 5);

    // Illegal code, then a repeated code that only stalls once locked.
    step("illegal", 1'b1, 1'b1, 4'b0101, 1'b0);
    feed("rep_a", 2);
    feed("rep_b", 2);
    feed("rep_lock", 3);
    feed("rep_stall", 3);
    check("stall_pulse", {31'd0, stall}, 32'd1);

    // Error counter saturation and clear priority.
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 1'b1, 4'b1010, 1'b0);
    check("err_sat", {24'd0, err_cnt}, 32'd255);
    step("clr_vs_illegal", 1'b1, 1'b1, 4'b1001, 1'b1);

    // Hold while en is low, with code_in moving; clear still works.
    for (int i = 0; i < 4; i++) feed("relock2", i);
    step("err_up", 1'b1, 1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 4; i++) feed("relock3", i);
    for (int i = 0; i < 5; i++) step("en_low", 1'b1, 1'b0, 4'($urandom), 1'b0);
    step("clr_en_low", 1'b1, 1'b0, 4'b0110, 1'b1);

    // Reset in the middle of a locked sequence.
    step("mid_reset", 1'b0, 1'b1, codes[4], 1'b0);
    feed("after_reset", 5);

    // Randomized traffic: mostly forward steps, with some stalls, jumps,
    // illegal codes, idle cycles, clears and resets.
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      c = codes[(m_idx + 1) % 8];
      else if (r < 65) c = codes[m_idx];
      else if (r < 80) c = codes[$urandom_range(0, 7)];
      else             c = 4'($urandom);
      step("random", ($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 8), c,
           ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/john_decoder.md
JOHN_DECODER -- requirements
Module: john_decoder

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
  clk       in   1  rising-edge clock
  rst       in   1  synchronous reset, active-low
  en        in   1  sample qualifier; code_in sampled only when en=1
  code_in   in   4  4-bit Johnson code from a counter stage
  err_clr   in   1  synchronous clear of err_cnt
  count     out  3  binary index of last legal sample
  valid     out  1  1 = last sample was a legal code
  locked    out  1  1 = FSM in LOCKED
  seq_err   out  1  one-cycle pulse: legal code out of sequence while LOCKED
  illegal   out  1  one-cycle pulse: sampled code not in Johnson set
  stall     out  1  one-cycle pulse: LOCKED sample equal to previous code
  wrap      out  1  one-cycle pulse: LOCKED transition index 7 -> 0
  err_cnt   out  8  saturating count of seq_err + illegal events
REQ-002 The block SHALL have no parameters; width is fixed at 4 bits (8 legal codes).

Function
REQ-003 Decode map (code_in[3:0] -> index) SHALL be: 0000->0, 1000->1, 1100->2, 1110->3, 1111->4, 0111->5, 0011->6, 0001->7; the other 8 codes are illegal.
REQ-004 Successor of index i SHALL be (i+1) mod 8; no reverse-direction acceptance.
REQ-005 All outputs SHALL be registered; a sample at edge k (en=1) is reflected on outputs after edge k; latency one clock.
REQ-006 When en=0 at an edge, FSM, count, valid, err_cnt SHALL hold, and all pulse outputs SHALL be 0.
REQ-007 On a legal sample count SHALL load the decoded index and valid SHALL be 1; on an illegal sample count SHALL hold and valid SHALL be 0.
REQ-008 FSM states SHALL be SEARCH, CONFIRM, LOCKED; locked=1 only in LOCKED.
REQ-009 SEARCH: legal sample -> CONFIRM (store index); illegal -> stay SEARCH, illegal=1.
REQ-010 CONFIRM: sample = successor(stored) -> LOCKED; legal non-successor -> stay CONFIRM, store new index; illegal -> SEARCH, illegal=1; no seq_err in CONFIRM.
REQ-011 LOCKED: successor -> stay LOCKED; equal to stored -> stay LOCKED, stall=1; other legal -> CONFIRM, seq_err=1, store new index; illegal -> SEARCH, illegal=1.
REQ-012 wrap SHALL pulse only for a LOCKED->LOCKED successor transition from index 7 to 0.
REQ-013 err_cnt SHALL increment by 1 per seq_err or illegal event and saturate at 255 (no wrap).
REQ-014 err_clr=1 SHALL set err_cnt to 0 at that edge, taking precedence over a simultaneous error event; err_clr SHALL work regardless of en.
REQ-015 At most one of seq_err, illegal, stall SHALL be 1 in any cycle.

Reset
REQ-016 With rst=0 at a rising edge: FSM=SEARCH, stored index=0, count=0, valid=0, locked=0, seq_err=0, illegal=0, stall=0, wrap=0, err_cnt=0.
REQ-017 rst SHALL take precedence over en and err_clr; reset mid-sequence discards lock and stored index.
REQ-018 First edge after rst returns high SHALL be treated as a normal sample per REQ-006..011.

Verification
REQ-019 Reset, en=1, feed 0000,1000,1100,1110 -> locked=1 after 2nd sample edge; count 0,1,2,3; no pulses.
REQ-020 Locked, feed full cycle ...,0011,0001,0000 -> wrap=1 exactly on 0001->0000 cycle, count=0, locked stays 1.
REQ-021 Locked at 1100, feed 1111 -> seq_err=1, locked=0 (CONFIRM), count=4, err_cnt+1; next 0111 -> locked=1.
REQ-022 Locked, feed 0101 -> illegal=1, valid=0, count held, FSM=SEARCH, err_cnt+1; repeated 1100 then 1100 -> stall only after relock.
REQ-023 Inject 300 illegal codes -> err_cnt=255 held; err_clr=1 with simultaneous illegal -> err_cnt=0.
REQ-024 Locked, en=0 for 5 cycles with code_in changing -> all outputs hold, pulses 0; rst=0 mid-sequence -> all outputs per REQ-016 next cycle.
